seg7_scan_driver: RTL and testbench

- Drives a 4-digit multiplexed 7-segment display on the ADC wing from a 16-bit value, one hex nibble per digit.
- Sits downstream of the 1 Hz sample-and-hold stage and consumes its 16-bit held value.
- Captures on a load strobe and double-buffers the value so a digit never changes mid-frame (no tearing).
- Adds time-multiplexed scanning, ghost suppression, leading-zero blanking and decimal-point control.

---
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Scans a 4-digit multiplexed 7-segment display from a 16-bit hex value.
// A load is held in a shadow register and only moves to the display
// register at the end of a full frame, so digits never tear mid-scan.
// Each digit slot starts with a short all-off gap to suppress ghosting.

module seg7_scan_driver #(
  parameter int SCAN_DIV     = 10,
  parameter int COMMON_ANODE = 1,
  parameter int BLANK_LZ     = 1,
  parameter int GHOST        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done,
  output logic [15:0] shown_data
);

  localparam logic                INV       = (COMMON_ANODE != 0);
  localparam logic                LZ_EN     = (BLANK_LZ != 0);
  localparam logic [SCAN_DIV-1:0] GHOST_CNT = SCAN_DIV'(GHOST);

  logic [SCAN_DIV-1:0] cnt;
  logic [1:0]          dig;
  logic [15:0]         sh_data;
  logic [3:0]          sh_dp;
  logic                pending;
  logic [15:0]         disp_data;
  logic [3:0]          disp_dp;

  logic                slot_end;
  logic                boundary;
  logic [3:0]          nib;
  logic                lz;
  logic                on;
  logic [3:0]          an_hi;
  logic [6:0]          seg_hi;
  logic                dp_hi;

  // Hex to active-high gfedcba segment pattern
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign slot_end   = &cnt;
  assign boundary   = slot_end && (dig == 2'd3);
  assign shown_data = disp_data;

  // Select and decode the digit for the current slot (active-high form)
  always_comb begin
    nib    = disp_data[{dig, 2'b00} +: 4];
    lz     = 1'b0;
    case (dig)
      2'd3:    lz = (disp_data[15:12] == 4'h0);
      2'd2:    lz = (disp_data[15:8] == 8'h00);
      2'd1:    lz = (disp_data[15:4] == 12'h000);
      default: lz = 1'b0;
    endcase
    lz     = lz && LZ_EN;
    on     = (cnt >= GHOST_CNT) && !blank;
    an_hi  = on ? (4'b0001 << dig) : 4'b0000;
    seg_hi = (on && !lz) ? hex7(nib) : 7'h00;
    dp_hi  = on && disp_dp[dig];
  end

  // Scan counters, frame pulse, double buffer and polarity-adjusted outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      dig        <= 2'd0;
      sh_data    <= 16'h0000;
      sh_dp      <= 4'h0;
      pending    <= 1'b0;
      disp_data  <= 16'h0000;
      disp_dp    <= 4'h0;
      frame_done <= 1'b0;
      an         <= {4{INV}};
      seg        <= {7{INV}};
      dp         <= INV;
    end else begin
      cnt        <= cnt + 1'b1;
      if (slot_end) dig <= dig + 2'd1;
      frame_done <= boundary;

      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          disp_data <= data_in;
          disp_dp   <= dp_in;
        end else if (pending) begin
          disp_data <= sh_data;
          disp_dp   <= sh_dp;
        end
      end else if (load) begin
        sh_data <= data_in;
        sh_dp   <= dp_in;
        pending <= 1'b1;
      end

      an  <= an_hi ^ {4{INV}};
      seg <= seg_hi ^ {7{INV}};
      dp  <= dp_hi ^ INV;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Drives directed scenarios and random traffic into the scan driver and
// compares every cycle against a frame/slot-position reference model.

module tb_seg7_scan_driver;

  localparam int SCAN_DIV = 4;
  localparam int GHOST    = 4;
  localparam int SLOT     = 1 << SCAN_DIV;
  localparam int FRAME    = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  logic [15:0] shown_data;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          m_cyc = 0;
  logic [15:0] m_disp = 16'h0;
  logic [3:0]  m_disp_dp = 4'h0;
  logic [15:0] m_sh = 16'h0;
  logic [3:0]  m_sh_dp = 4'h0;
  logic        m_pend = 1'b0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fd;
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_driver #(
    .SCAN_DIV(SCAN_DIV), .COMMON_ANODE(1), .BLANK_LZ(1), .GHOST(GHOST)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .dp_in(dp_in),
    .blank(blank), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done),
    .shown_data(shown_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, m_cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare
  task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] d,
                               input logic [3:0] dpv, input logic blk);
    int pos, slot, digit;
    logic on, lzb;
    @(negedge clk);
    rst = r; load = ld; data_in = d; dp_in = dpv; blank = blk;
    @(posedge clk);
    if (r) begin
      m_cyc = 0; m_disp = 16'h0; m_disp_dp = 4'h0; m_sh = 16'h0; m_sh_dp = 4'h0;
      m_pend = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      pos   = m_cyc % FRAME;
      slot  = pos % SLOT;
      digit = pos / SLOT;
      on    = (slot >= GHOST) && !blk;
      lzb   = (digit > 0) && ((m_disp >> (4 * digit)) == 16'h0);
      e_an  = on ? ~(4'b0001 << digit) : 4'hF;
      e_seg = (on && !lzb) ? ~hex_tab[(m_disp >> (4 * digit)) & 16'hF] : 7'h7F;
      e_dp  = on ? ~m_disp_dp[digit] : 1'b1;
      e_fd  = (pos == FRAME - 1);
      if (pos == FRAME - 1) begin
        if (ld) begin
          m_disp = d; m_disp_dp = dpv;
        end else if (m_pend) begin
          m_disp = m_sh; m_disp_dp = m_sh_dp;
        end
        m_pend = 1'b0;
      end else if (ld) begin
        m_sh = d; m_sh_dp = dpv; m_pend = 1'b1;
      end
      m_cyc++;
    end
    #1;
    checkOutput("an", {12'h0, an}, {12'h0, e_an});
    checkOutput("seg", {9'h0, seg}, {9'h0, e_seg});
    checkOutput("dp", {15'h0, dp}, {15'h0, e_dp});
    checkOutput("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
    checkOutput("shown_data", shown_data, m_disp);
  endtask

  task automatic idle(input int n, input logic blk);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, blk);
  endtask

  // Run until the next clock is the last cycle of a frame
  task automatic toBoundary();
    for (int i = 0; i < FRAME && (m_cyc % FRAME) != FRAME - 1; i++) idle(1, 1'b0);
  endtask

  initial begin
    int fd_seen;
    // Reset then idle: digit 0 shows 0, others blank
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(FRAME + 4, 1'b0);

    // Mid-frame load, then two full frames to see it displayed
    idle(10, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h12AF, 4'b0100, 1'b0);
    idle(2 * FRAME, 1'b0);
    checkOutput("shown_12AF", shown_data, 16'h12AF);

    // Two loads in one frame, last one wins
    idle(5, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1111, 4'h1, 1'b0);
    idle(7, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h2222, 4'h2, 1'b0);
    idle(FRAME, 1'b0);
    checkOutput("shown_2222", shown_data, 16'h2222);

    // Load coincident with the frame boundary goes straight to display
    toBoundary();
    applyStimulus(1'b0, 1'b1, 16'h0050, 4'h0, 1'b0);
    checkOutput("shown_0050", shown_data, 16'h0050);
    idle(FRAME + 2, 1'b0);

    // Blank for a whole frame, frame pulse and transfer continue
    fd_seen = 0;
    for (int i = 0; i < FRAME; i++) begin
      applyStimulus(1'b0, (i == 20), 16'hBEEF, 4'h9, 1'b1);
      if (frame_done) fd_seen++;
    end
    checkOutput("fd_during_blank", 16'(fd_seen), 16'd1);
    idle(4, 1'b0);
    checkOutput("shown_BEEF", shown_data, 16'hBEEF);

    // Reset during the digit-2 slot, then recover
    for (int i = 0; i < FRAME && (m_cyc % FRAME) != 2 * SLOT + 6; i++) idle(1, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    checkOutput("shown_after_rst", shown_data, 16'h0000);
    idle(FRAME + 8, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 699) == 0), ($urandom_range(0, 24) == 0),
                    16'($urandom), 4'($urandom),
                    (($urandom_range(0, 7) == 0) ? 1'b1 : (($urandom_range(0, 1) == 0) ? blank : 1'b0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
